// File: rtl/iob_soc_versat_mem_merge.sv
// N-master IOb merge: round-robin arbiter with grant lock, in-order read tag FIFO and L2 invalidate sequencer.
// Define IOB_MERGE_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module iob_soc_versat_mem_merge #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int PEND_W    = 2
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic [N_MASTERS-1:0]            m_valid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb_i,
  output logic [N_MASTERS*DATA_W-1:0]     m_rdata_o,
  output logic [N_MASTERS-1:0]            m_rvalid_o,
  output logic [N_MASTERS-1:0]            m_ready_o,
  output logic                            s_valid_o,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  output logic [DATA_W/8-1:0]             s_wstrb_o,
  input  logic [DATA_W-1:0]               s_rdata_i,
  input  logic                            s_rvalid_i,
  input  logic                            s_ready_i,
  input  logic                            inv_req_i,
  output logic                            inv_o,
  output logic                            inv_busy_o,
  output logic                            err_o
);
  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 1 << PEND_W;

  typedef enum logic [1:0] {INV_IDLE, INV_WAIT, INV_FIRE} inv_state_t;

  inv_state_t          inv_state_q;
  logic                lock_q;
  logic [IDX_W-1:0]    lock_idx_q;
  logic [IDX_W-1:0]    tag_q [DEPTH];
  logic [PEND_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PEND_W:0]     cnt_q, cnt_d;
  logic                err_q;
`ifndef IOB_MERGE_FIXED_PRIO_EN
  logic [IDX_W-1:0]    rr_ptr_q;
  int                  scan_idx;
`endif

  logic [N_MASTERS-1:0] eligible;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld, xfer, push, pop, full, empty;

  assign full  = (cnt_q == (PEND_W+1)'(DEPTH));
  assign empty = (cnt_q == '0);

  // Reads are held off while the tag FIFO is full; writes never need a tag.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++)
      eligible[i] = m_valid_i[i] & ~((~|m_wstrb_i[i*STRB_W +: STRB_W]) & full);
  end

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
`ifndef IOB_MERGE_FIXED_PRIO_EN
    scan_idx = 0;
`endif
    if (lock_q) begin
      gnt_idx = lock_idx_q;
      gnt_vld = m_valid_i[lock_idx_q];
    end else if (inv_state_q == INV_IDLE) begin
      // Scan downward so the last hit is the highest-priority candidate.
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
`ifdef IOB_MERGE_FIXED_PRIO_EN
        if (eligible[i]) begin
          gnt_idx = IDX_W'(i);
          gnt_vld = 1'b1;
        end
`else
        scan_idx = (int'(rr_ptr_q) + i) % N_MASTERS;
        if (eligible[scan_idx]) begin
          gnt_idx = IDX_W'(scan_idx);
          gnt_vld = 1'b1;
        end
`endif
      end
    end
  end

  assign s_valid_o = gnt_vld;
  assign s_addr_o  = gnt_vld ? m_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W] : '0;
  assign s_wdata_o = gnt_vld ? m_wdata_i[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
  assign s_wstrb_o = gnt_vld ? m_wstrb_i[int'(gnt_idx)*STRB_W +: STRB_W] : '0;

  assign xfer  = gnt_vld & s_ready_i;
  assign push  = xfer & ~|s_wstrb_o;
  assign pop   = s_rvalid_i & ~empty;
  assign cnt_d = cnt_q + (PEND_W+1)'(push) - (PEND_W+1)'(pop);

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      m_ready_o[i]  = xfer & (gnt_idx == IDX_W'(i));
      m_rvalid_o[i] = pop & (tag_q[rd_ptr_q] == IDX_W'(i));
    end
  end

  assign m_rdata_o  = {N_MASTERS{s_rdata_i}};
  assign inv_o      = (inv_state_q == INV_FIRE);
  assign inv_busy_o = (inv_state_q != INV_IDLE);
  assign err_o      = err_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      inv_state_q <= INV_IDLE;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
`ifndef IOB_MERGE_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      lock_q <= gnt_vld & ~s_ready_i;
      if (gnt_vld & ~s_ready_i) lock_idx_q <= gnt_idx;
`ifndef IOB_MERGE_FIXED_PRIO_EN
      if (xfer) rr_ptr_q <= (int'(gnt_idx) == N_MASTERS - 1) ? '0 : gnt_idx + 1'b1;
`endif
      if (push) begin
        tag_q[wr_ptr_q] <= gnt_idx;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      if (s_rvalid_i & empty) err_q <= 1'b1;
      // Requests arriving in WAIT/FIRE merge into the pending invalidate.
      case (inv_state_q)
        INV_IDLE: if (inv_req_i) inv_state_q <= INV_WAIT;
        INV_WAIT: if (~gnt_vld & ~lock_q & (cnt_d == '0)) inv_state_q <= INV_FIRE;
        default:  inv_state_q <= INV_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iob_soc_versat_mem_merge.sv
// Directed bench for iob_soc_versat_mem_merge with a read-tag scoreboard and an in-bench slave model.
module tb_iob_soc_versat_mem_merge;
  localparam int N      = 3;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = 2;
  localparam int LAT    = 2;

  logic                  clk_i = 1'b0;
  logic                  arst_i;
  logic [N-1:0]          m_valid_i;
  logic [N*ADDR_W-1:0]   m_addr_i;
  logic [N*DATA_W-1:0]   m_wdata_i;
  logic [N*STRB_W-1:0]   m_wstrb_i;
  logic [N*DATA_W-1:0]   m_rdata_o;
  logic [N-1:0]          m_rvalid_o, m_ready_o;
  logic                  s_valid_o;
  logic [ADDR_W-1:0]     s_addr_o;
  logic [DATA_W-1:0]     s_wdata_o;
  logic [STRB_W-1:0]     s_wstrb_o;
  logic [DATA_W-1:0]     s_rdata_i;
  logic                  s_rvalid_i, s_ready_i, inv_req_i;
  logic                  inv_o, inv_busy_o, err_o;

  iob_soc_versat_mem_merge #(.N_MASTERS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PEND_W(2)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .m_valid_i(m_valid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
    .m_rdata_o(m_rdata_o), .m_rvalid_o(m_rvalid_o), .m_ready_o(m_ready_o),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_rdata_i(s_rdata_i), .s_rvalid_i(s_rvalid_i), .s_ready_i(s_ready_i),
    .inv_req_i(inv_req_i), .inv_o(inv_o), .inv_busy_o(inv_busy_o), .err_o(err_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  bit auto_rsp = 1'b0;
  bit man_rsp  = 1'b0;

  logic               va [N];
  logic [ADDR_W-1:0]  ad [N];
  logic [DATA_W-1:0]  wd [N];
  logic [STRB_W-1:0]  ws [N];

  // scoreboard: issuing master of every accepted read, plus the slave's pending reads
  logic [IDX_W-1:0]   exp_q [$];
  logic [ADDR_W-1:0]  sq_addr [$];
  int                 sq_cyc [$];

  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    return {8'hC3, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      m_valid_i[i] = va[i];
      m_addr_i[i*ADDR_W +: ADDR_W] = ad[i];
      m_wdata_i[i*DATA_W +: DATA_W] = wd[i];
      m_wstrb_i[i*STRB_W +: STRB_W] = ws[i];
    end
  endtask

  task automatic set_m(input int i, input logic v, input logic [STRB_W-1:0] s);
    va[i] = v;
    ws[i] = s;
  endtask

  // One cycle: apply inputs, model slave response, check, advance to posedge+1.
  // exp_g: expected accepted master (-1 none); hold: master whose request must be presented but not accepted.
  task automatic step(input int exp_g, input int hold = -1);
    logic [ADDR_W-1:0] a;
    logic [IDX_W-1:0]  g;
    a = '0;
    drive();
    s_rvalid_i = 1'b0;
    if (man_rsp || (auto_rsp && sq_addr.size() > 0 && cycle >= sq_cyc[0] + LAT)) begin
      s_rvalid_i = 1'b1;
      if (sq_addr.size() > 0) begin
        a = sq_addr.pop_front();
        void'(sq_cyc.pop_front());
        s_rdata_i = rd_val(a);
      end else begin
        s_rdata_i = 32'hDEAD_0BAD;
      end
    end
    man_rsp = 1'b0;
    #1;
    if (s_rvalid_i) begin
      if (exp_q.size() > 0) begin
        g = exp_q.pop_front();
        chk("rvalid_route", 64'(m_rvalid_o), 64'(1 << g));
        chk("rdata", 64'(m_rdata_o[int'(g)*DATA_W +: DATA_W]), 64'(rd_val(a)));
      end else begin
        chk("rvalid_spurious", 64'(m_rvalid_o), 64'd0);
      end
    end
    if (exp_g >= 0) begin
      chk("m_ready", 64'(m_ready_o), 64'(1 << exp_g));
      chk("s_addr", 64'(s_addr_o), 64'(ad[exp_g]));
      chk("s_wstrb", 64'(s_wstrb_o), 64'(ws[exp_g]));
      if (ws[exp_g] != '0) chk("s_wdata", 64'(s_wdata_o), 64'(wd[exp_g]));
      if (ws[exp_g] == '0) begin
        sq_addr.push_back(ad[exp_g]);
        sq_cyc.push_back(cycle);
        exp_q.push_back(IDX_W'(exp_g));
      end
    end else begin
      chk("m_ready_none", 64'(m_ready_o), 64'd0);
      if (hold >= 0) begin
        chk("hold_valid", 64'(s_valid_o), 64'd1);
        chk("hold_addr", 64'(s_addr_o), 64'(ad[hold]));
      end else begin
        chk("s_valid_idle", 64'(s_valid_o), 64'd0);
      end
    end
    @(posedge clk_i);
    #1;
    cycle++;
    s_rvalid_i = 1'b0;
    inv_req_i  = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) set_m(i, 1'b0, '0);
    drive();
    s_ready_i  = 1'b1;
    s_rvalid_i = 1'b0;
    inv_req_i  = 1'b0;
    s_rdata_i  = 32'h5A5A_1234;
    arst_i     = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_s_valid", 64'(s_valid_o), 64'd0);
    chk("rst_s_addr", 64'(s_addr_o), 64'd0);
    chk("rst_m_ready", 64'(m_ready_o), 64'd0);
    chk("rst_m_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("rst_inv", 64'({inv_o, inv_busy_o}), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rdata", 64'(m_rdata_o[2*DATA_W +: DATA_W]), 64'h5A5A_1234);
    arst_i = 1'b0;
    exp_q.delete();
    sq_addr.delete();
    sq_cyc.delete();
    #1;
  endtask

  task automatic chk_inv(input logic o, input logic busy);
    chk("inv_o", 64'(inv_o), 64'(o));
    chk("inv_busy", 64'(inv_busy_o), 64'(busy));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ad[i] = ADDR_W'(24'h10_0000 * (i + 1) + 24'h40 * i);
      wd[i] = 32'hA000_0000 + 32'(i);
      ws[i] = '0;
      va[i] = 1'b0;
    end

    // 1: all masters reading continuously, slave answers 2 cycles later
    do_reset();
    auto_rsp = 1'b1;
    for (int i = 0; i < N; i++) set_m(i, 1'b1, '0);
    for (int k = 0; k < 9; k++) begin
`ifdef IOB_MERGE_FIXED_PRIO_EN
      step(0);
`else
      step(k % N);
`endif
    end
    for (int i = 0; i < N; i++) set_m(i, 1'b0, '0);
    for (int k = 0; k < 4; k++) step(-1);
    chk("t1_drained", 64'(exp_q.size()), 64'd0);
    chk("t1_err", 64'(err_o), 64'd0);

    // 2: lock holds the grant while the slave stalls
    do_reset();
    set_m(0, 1'b1, '0);
    set_m(1, 1'b1, '0);
    s_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) step(-1, 0);
    s_ready_i = 1'b1;
    step(0);
    set_m(0, 1'b0, '0);
    step(1);
    set_m(1, 1'b0, '0);
    set_m(2, 1'b1, '0);
    s_ready_i = 1'b0;
    step(-1, 2);
    set_m(1, 1'b1, '0);
    step(-1, 2);
    step(-1, 2);
    s_ready_i = 1'b1;
    step(2);
    set_m(2, 1'b0, '0);
    step(1);
    set_m(1, 1'b0, '0);
    for (int k = 0; k < 4; k++) step(-1);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: full tag FIFO blocks reads, not writes; same-cycle pop does not unblock
    do_reset();
    auto_rsp = 1'b0;
    set_m(0, 1'b1, '0);
    for (int k = 0; k < 4; k++) step(0);
    set_m(1, 1'b1, 4'hF);
    step(1);
    set_m(1, 1'b0, '0);
    step(-1);
    man_rsp = 1'b1;
    step(-1);
    step(0);
    set_m(0, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      man_rsp = 1'b1;
      step(-1);
    end
    chk("t3_drained", 64'(exp_q.size()), 64'd0);
    chk("t3_err", 64'(err_o), 64'd0);

    // 4: invalidate waits for outstanding reads, merges a repeated request
    do_reset();
    set_m(0, 1'b1, '0);
    step(0);
    step(0);
    set_m(0, 1'b0, '0);
    inv_req_i = 1'b1;
    step(-1);
    set_m(1, 1'b1, '0);
    chk_inv(1'b0, 1'b1);
    step(-1);
    man_rsp = 1'b1;
    step(-1);
    inv_req_i = 1'b1;
    chk_inv(1'b0, 1'b1);
    step(-1);
    man_rsp = 1'b1;
    step(-1);
    chk_inv(1'b1, 1'b1);
    step(-1);
    chk_inv(1'b0, 1'b0);
    step(1);
    set_m(1, 1'b0, '0);
    chk_inv(1'b0, 1'b0);
    step(-1);
    chk_inv(1'b0, 1'b0);
    man_rsp = 1'b1;
    step(-1);

    // 5: spurious response sets sticky err_o
    do_reset();
    man_rsp = 1'b1;
    step(-1);
    chk("t5_err_set", 64'(err_o), 64'd1);
    step(-1);
    step(-1);
    chk("t5_err_sticky", 64'(err_o), 64'd1);
    set_m(0, 1'b1, '0);
    step(0);
    set_m(0, 1'b0, '0);
    do_reset();
    man_rsp = 1'b1;
    step(-1);
    chk("t5_err_after_reset", 64'(err_o), 64'd1);

`ifdef IOB_MERGE_FIXED_PRIO_EN
    // 6: fixed priority starves m2 while m0 requests
    do_reset();
    auto_rsp = 1'b1;
    set_m(0, 1'b1, '0);
    set_m(2, 1'b1, '0);
    for (int k = 0; k < 6; k++) step(0);
    set_m(0, 1'b0, '0);
    step(2);
    set_m(2, 1'b0, '0);
    for (int k = 0; k < 4; k++) step(-1);
    chk("t6_drained", 64'(exp_q.size()), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
